// File: rtl/display_pkg.sv
// Purpose: shared display-pipeline definitions: hve bus bit positions and sequencer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package display_pkg;

  // Bit positions inside the {hsync, vsync, de} bus produced by display_signal
  localparam int HVE_HSYNC = 2;
  localparam int HVE_VSYNC = 1;
  localparam int HVE_DE    = 0;

  // SYNC waits for the first frame boundary; RUN schedules patterns frame by frame
  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Purpose: rising-edge detector with a combinational edge and a registered one-cycle pulse.
// Latency: rise is same-cycle; rise_q is one cycle after the input is first sampled high.
// Backpressure: none; free-running on every clock.
module sync_edge_detect #(
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic rise_q
);

  logic din_d;

  // The history bit resets to RESET_LEVEL so a level already high at reset exit is not an edge
  assign rise = din & ~din_d;

  // Track the previous input level and register the edge pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      din_d  <= RESET_LEVEL;
      rise_q <= 1'b0;
    end else begin
      din_d  <= din;
      rise_q <= rise;
    end
  end

endmodule

// File: rtl/frame_pattern_sequencer.sv
// Purpose: frame-synchronous pattern index scheduler; advances on a frame count or a manual request.
// Latency: all outputs registered; o_pattern/o_switch/o_frame_start update the cycle after vsync rises.
// Backpressure: one manual request is held pending at a time; a further request waits un-acked.
module frame_pattern_sequencer
  import display_pkg::*;
#(
  parameter int NUM_PATTERNS       = 4,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter bit AUTO_ADVANCE       = 1'b1,
  localparam int PAT_W             = $clog2(NUM_PATTERNS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       i_hve,
  input  logic             i_next_req,
  output logic             o_next_ack,
  input  logic             i_hold,
  output logic [PAT_W-1:0] o_pattern,
  output logic             o_pattern_valid,
  output logic             o_frame_start,
  output logic             o_switch,
  output logic [15:0]      o_frame_cnt
);

  localparam logic [PAT_W-1:0] LAST_PAT   = PAT_W'(NUM_PATTERNS - 1);
  localparam logic [15:0]      EXPIRE_CNT = 16'(FRAMES_PER_PATTERN - 1);

  seq_state_t state;
  logic       pending;
  logic       fs;
  logic       fs_q;
  logic       accept;
  logic       auto_due;
  logic       adv;
  logic       unused_hve;

  // Only vsync matters here; hsync and de are deliberately ignored
  assign unused_hve = i_hve[HVE_HSYNC] ^ i_hve[HVE_DE];

  // vsync history resets high so a vsync already asserted at reset exit is not a frame start
  sync_edge_detect #(
    .RESET_LEVEL(1'b1)
  ) u_vs_edge (
    .clk    (clk),
    .reset  (reset),
    .din    (i_hve[HVE_VSYNC]),
    .rise   (fs),
    .rise_q (fs_q)
  );

  assign o_frame_start = fs_q;

  // A request is taken only when nothing is pending; it is applied at a later frame start
  assign accept   = i_next_req & ~pending;
  // >= rather than == so a count that ran past expiry under hold advances once hold drops
  assign auto_due = AUTO_ADVANCE & ~i_hold & (o_frame_cnt >= EXPIRE_CNT);
  assign adv      = pending | auto_due;

  // Sequencer FSM, frame counter and manual handshake, all registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= SYNC;
      pending         <= 1'b0;
      o_next_ack      <= 1'b0;
      o_pattern       <= '0;
      o_pattern_valid <= 1'b0;
      o_switch        <= 1'b0;
      o_frame_cnt     <= '0;
    end else begin
      o_switch   <= 1'b0;
      o_next_ack <= accept;

      if (state == SYNC) begin
        // First boundary only establishes frame alignment; nothing advances here
        if (fs) begin
          state           <= RUN;
          o_pattern_valid <= 1'b1;
          o_frame_cnt     <= '0;
        end
      end else begin
        if (fs) begin
          if (adv) begin
            // Pending and expiry on the same edge collapse into a single step
            o_pattern   <= (o_pattern == LAST_PAT) ? '0 : o_pattern + 1'b1;
            o_frame_cnt <= '0;
            o_switch    <= 1'b1;
            pending     <= 1'b0;
          end else if (o_frame_cnt != 16'hFFFF) begin
            o_frame_cnt <= o_frame_cnt + 16'd1;
          end
        end
      end

      // A request accepted on a frame-start edge survives to the next edge
      if (accept) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_pattern_sequencer.sv
// Purpose: directed self-checking bench for frame_pattern_sequencer (FPP=3, 4 patterns, auto on).
// Latency: checks outputs one clock after each stimulus change, sampled #1 after the edge.
// Backpressure: manual requests are held for a fixed number of cycles and acks are counted.
module tb_frame_pattern_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        vs;
  logic [2:0]  i_hve;
  logic        i_next_req;
  logic        o_next_ack;
  logic        i_hold;
  logic [1:0]  o_pattern;
  logic        o_pattern_valid;
  logic        o_frame_start;
  logic        o_switch;
  logic [15:0] o_frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          hold;
    bit          req;
    logic [1:0]  pat;
    logic [15:0] cnt;
    bit          sw;
  } vec_t;

  vec_t vq[$];

  assign i_hve = {1'b0, vs, 1'b0};

  always #5 clk = ~clk;

  frame_pattern_sequencer #(
    .NUM_PATTERNS       (4),
    .FRAMES_PER_PATTERN (3),
    .AUTO_ADVANCE       (1'b1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_hve           (i_hve),
    .i_next_req      (i_next_req),
    .o_next_ack      (o_next_ack),
    .i_hold          (i_hold),
    .o_pattern       (o_pattern),
    .o_pattern_valid (o_pattern_valid),
    .o_frame_start   (o_frame_start),
    .o_switch        (o_switch),
    .o_frame_cnt     (o_frame_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One frame: vsync low, optional manual request, then a vsync rise and checks
  task automatic do_frame(input vec_t v);
    int acks;
    i_hold = v.hold;
    vs = 1'b0;
    step();
    step();
    if (v.req) begin
      i_next_req = 1'b1;
      acks = 0;
      repeat (5) begin
        step();
        if (o_next_ack) acks++;
      end
      i_next_req = 1'b0;
      step();
      if (o_next_ack) acks++;
      chk("ack_count", acks, 1);
    end
    step();
    vs = 1'b1;
    step();
    chk("frame_start", int'(o_frame_start), 1);
    chk("switch", int'(o_switch), int'(v.sw));
    chk("pattern", int'(o_pattern), int'(v.pat));
    chk("frame_cnt", int'(o_frame_cnt), int'(v.cnt));
    step();
    chk("frame_start_clear", int'(o_frame_start), 0);
    chk("switch_clear", int'(o_switch), 0);
  endtask

  initial begin
    int starts;
    int acks;

    // Frames 1..13: plain auto advance every 3 RUN frames
    vq.push_back('{0, 0, 2'd0, 16'd1, 0});
    vq.push_back('{0, 0, 2'd0, 16'd2, 0});
    vq.push_back('{0, 0, 2'd1, 16'd0, 1});
    vq.push_back('{0, 0, 2'd1, 16'd1, 0});
    vq.push_back('{0, 0, 2'd1, 16'd2, 0});
    vq.push_back('{0, 0, 2'd2, 16'd0, 1});
    vq.push_back('{0, 0, 2'd2, 16'd1, 0});
    vq.push_back('{0, 0, 2'd2, 16'd2, 0});
    vq.push_back('{0, 0, 2'd3, 16'd0, 1});
    vq.push_back('{0, 0, 2'd3, 16'd1, 0});
    vq.push_back('{0, 0, 2'd3, 16'd2, 0});
    vq.push_back('{0, 0, 2'd0, 16'd0, 1});
    vq.push_back('{0, 0, 2'd0, 16'd1, 0});
    // Manual request mid-count
    vq.push_back('{0, 1, 2'd1, 16'd0, 1});
    vq.push_back('{0, 0, 2'd1, 16'd1, 0});
    vq.push_back('{0, 0, 2'd1, 16'd2, 0});
    // Request pending at the same edge as auto expiry: a single step
    vq.push_back('{0, 1, 2'd2, 16'd0, 1});
    vq.push_back('{0, 0, 2'd2, 16'd1, 0});
    // Hold for 10 frames: count runs past expiry with no switch
    vq.push_back('{1, 0, 2'd2, 16'd2, 0});
    vq.push_back('{1, 0, 2'd2, 16'd3, 0});
    vq.push_back('{1, 0, 2'd2, 16'd4, 0});
    vq.push_back('{1, 0, 2'd2, 16'd5, 0});
    vq.push_back('{1, 0, 2'd2, 16'd6, 0});
    vq.push_back('{1, 0, 2'd2, 16'd7, 0});
    vq.push_back('{1, 0, 2'd2, 16'd8, 0});
    vq.push_back('{1, 0, 2'd2, 16'd9, 0});
    vq.push_back('{1, 0, 2'd2, 16'd10, 0});
    vq.push_back('{1, 0, 2'd2, 16'd11, 0});
    // Manual advance honoured under hold, then hold drops past expiry
    vq.push_back('{1, 1, 2'd3, 16'd0, 1});
    vq.push_back('{1, 0, 2'd3, 16'd1, 0});
    vq.push_back('{1, 0, 2'd3, 16'd2, 0});
    vq.push_back('{1, 0, 2'd3, 16'd3, 0});
    vq.push_back('{0, 0, 2'd0, 16'd0, 1});
    vq.push_back('{0, 0, 2'd0, 16'd1, 0});
    // Walk to pattern 2 for the mid-run reset
    vq.push_back('{0, 0, 2'd0, 16'd2, 0});
    vq.push_back('{0, 0, 2'd1, 16'd0, 1});
    vq.push_back('{0, 0, 2'd1, 16'd1, 0});
    vq.push_back('{0, 0, 2'd1, 16'd2, 0});
    vq.push_back('{0, 0, 2'd2, 16'd0, 1});

    // Reset with vsync already high
    reset = 1'b1;
    vs = 1'b1;
    i_next_req = 1'b0;
    i_hold = 1'b0;
    repeat (3) step();
    chk("rst_pattern", int'(o_pattern), 0);
    chk("rst_valid", int'(o_pattern_valid), 0);
    chk("rst_cnt", int'(o_frame_cnt), 0);
    chk("rst_frame_start", int'(o_frame_start), 0);
    chk("rst_switch", int'(o_switch), 0);
    chk("rst_ack", int'(o_next_ack), 0);

    // vsync held high after reset exit must not look like an edge
    reset = 1'b0;
    starts = 0;
    repeat (4) begin
      step();
      if (o_frame_start) starts++;
    end
    vs = 1'b0;
    repeat (3) begin
      step();
      if (o_frame_start) starts++;
    end
    chk("no_start_before_fall", starts, 0);
    chk("valid_before_sync", int'(o_pattern_valid), 0);
    vs = 1'b1;
    step();
    chk("sync_frame_start", int'(o_frame_start), 1);
    chk("sync_valid", int'(o_pattern_valid), 1);
    chk("sync_pattern", int'(o_pattern), 0);
    chk("sync_cnt", int'(o_frame_cnt), 0);
    chk("sync_switch", int'(o_switch), 0);
    step();

    foreach (vq[i]) do_frame(vq[i]);

    // Reset in the middle of a frame with a request pending
    vs = 1'b0;
    step();
    chk("pre_reset_pattern", int'(o_pattern), 2);
    i_next_req = 1'b1;
    step();
    chk("pre_reset_ack", int'(o_next_ack), 1);
    reset = 1'b1;
    step();
    chk("mid_reset_pattern", int'(o_pattern), 0);
    chk("mid_reset_valid", int'(o_pattern_valid), 0);
    chk("mid_reset_cnt", int'(o_frame_cnt), 0);
    reset = 1'b0;
    acks = 0;
    repeat (3) begin
      step();
      if (o_next_ack) acks++;
    end
    chk("rehandshake_acks", acks, 1);
    i_next_req = 1'b0;
    step();
    vs = 1'b1;
    step();
    chk("resync_frame_start", int'(o_frame_start), 1);
    chk("resync_valid", int'(o_pattern_valid), 1);
    chk("resync_pattern", int'(o_pattern), 0);
    chk("resync_switch", int'(o_switch), 0);
    step();
    do_frame('{0, 0, 2'd1, 16'd0, 1});

    // Request accepted on the same edge as a frame start waits one frame
    vs = 1'b0;
    repeat (3) step();
    vs = 1'b1;
    i_next_req = 1'b1;
    step();
    chk("coincide_frame_start", int'(o_frame_start), 1);
    chk("coincide_ack", int'(o_next_ack), 1);
    chk("coincide_switch", int'(o_switch), 0);
    chk("coincide_pattern", int'(o_pattern), 1);
    chk("coincide_cnt", int'(o_frame_cnt), 1);
    i_next_req = 1'b0;
    step();
    do_frame('{0, 0, 2'd2, 16'd0, 1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
